// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gray_pkg
//  Description : Shared Gray-code helpers, mode constants and the operation
//                type used by the counter's next-state mux.
//  Revision    : 1.0  initial release
// ============================================================================
package gray_pkg;

   // Helpers work on vectors up to this width; callers zero-extend.
   localparam int GRAY_MAX_WIDTH = 64;

   // End-of-range behaviour selectors for the SATURATE parameter.
   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   // Operation selected for the current edge, in priority order.
   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_LOAD = 2'd1,
      OP_UP   = 2'd2,
      OP_DOWN = 2'd3
   } gray_op_e;

   // Zero-extended input keeps the result correct for any width up to the max.
   function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
      input logic [GRAY_MAX_WIDTH-1:0] bin_val
   );
      return bin_val ^ (bin_val >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits from the MSB down to it.
   function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
      input logic [GRAY_MAX_WIDTH-1:0] gray_val
   );
      logic [GRAY_MAX_WIDTH-1:0] res;
      res = '0;
      for (int i = 0; i < GRAY_MAX_WIDTH; i++) begin
         res[i] = ^(gray_val >> i);
      end
      return res;
   endfunction

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray2bin.sv
`default_nettype none
// ============================================================================
//  Module      : gray2bin
//  Description : Combinational Gray-to-binary converter (MSB-down prefix XOR).
//                Shared between the counter load path and pointer syncs.
//  Revision    : 1.0  initial release
// ============================================================================
module gray2bin #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   // Each bit is a reduction XOR of the Gray slice above it, so no bit
   // depends on another output bit and the chain flattens cleanly.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign bin[i] = ^gray[WIDTH-1:i];
   end

endmodule : gray2bin
`default_nettype wire

// File: rtl/gray_counter_n.sv
`default_nettype none
// ============================================================================
//  Module      : gray_counter_n
//  Description : N-bit up/down Gray counter with parallel Gray load, wrap or
//                saturate ends, sticky overflow/underflow flags and a
//                single-cycle boundary pulse. All outputs registered.
//  Revision    : 1.0  initial release
// ============================================================================
module gray_counter_n
   import gray_pkg::*;
#(
   parameter int WIDTH    = 3,
   parameter int SATURATE = MODE_WRAP
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             En,
   input  logic             Up,
   input  logic             Load,
   input  logic [WIDTH-1:0] Load_Gray,
   input  logic             Clr_Flags,
   output logic [WIDTH-1:0] Output,
   output logic [WIDTH-1:0] Binary,
   output logic             Overflow,
   output logic             Underflow,
   output logic             Wrap
);

   localparam logic [WIDTH-1:0] C_MAX_COUNT = '1;
   localparam logic [WIDTH-1:0] C_ONE       = WIDTH'(1);
   localparam bit               C_SAT       = (SATURATE == MODE_SAT);

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_overflow;
   logic             r_underflow;
   logic             r_wrap;

   gray_op_e         w_op;
   logic [WIDTH-1:0] w_load_bin;
   logic [WIDTH-1:0] w_next_bin;
   logic [WIDTH-1:0] w_next_gray;
   logic             w_at_max;
   logic             w_at_zero;
   logic             w_ovf_evt;
   logic             w_unf_evt;

   // Load path conversion
   gray2bin #(
      .WIDTH (WIDTH)
   ) u_load_g2b (
      .gray (Load_Gray),
      .bin  (w_load_bin)
   );

   assign w_at_max  = (r_bin == C_MAX_COUNT);
   assign w_at_zero = (r_bin == '0);

   // Operation select: load beats count, count beats hold
   always_comb begin
      w_op = OP_HOLD;
      if (Load) begin
         w_op = OP_LOAD;
      end else if (En) begin
         w_op = Up ? OP_UP : OP_DOWN;
      end
   end

   // Boundary events fire in both modes; only the next value differs
   assign w_ovf_evt = (w_op == OP_UP)   && w_at_max;
   assign w_unf_evt = (w_op == OP_DOWN) && w_at_zero;

   // Next binary count and its Gray image
   always_comb begin
      w_next_bin = r_bin;
      case (w_op)
         OP_LOAD: w_next_bin = w_load_bin;
         OP_UP: begin
            if (!w_at_max) begin
               w_next_bin = r_bin + C_ONE;
            end else if (!C_SAT) begin
               w_next_bin = '0;
            end
         end
         OP_DOWN: begin
            if (!w_at_zero) begin
               w_next_bin = r_bin - C_ONE;
            end else if (!C_SAT) begin
               w_next_bin = C_MAX_COUNT;
            end
         end
         default: w_next_bin = r_bin;
      endcase
      if (w_op == OP_LOAD) begin
         w_next_gray = Load_Gray;
      end else begin
         w_next_gray = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(w_next_bin)));
      end
   end

   // Count registers: binary and Gray always move together
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_bin  <= '0;
         r_gray <= '0;
      end else begin
         r_bin  <= w_next_bin;
         r_gray <= w_next_gray;
      end
   end

   // Sticky flags (a set beats a clear on the same edge) and boundary pulse
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_wrap      <= 1'b0;
      end else begin
         r_overflow  <= w_ovf_evt | (r_overflow  & ~Clr_Flags);
         r_underflow <= w_unf_evt | (r_underflow & ~Clr_Flags);
         r_wrap      <= w_ovf_evt | w_unf_evt;
      end
   end

   assign Output    = r_gray;
   assign Binary    = r_bin;
   assign Overflow  = r_overflow;
   assign Underflow = r_underflow;
   assign Wrap      = r_wrap;

endmodule : gray_counter_n
`default_nettype wire
